mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//   MEM-stage consumer of the EX/MEM pipeline register. Drives the data-memory
//   port from the M-stage fields and generates store byte enables and replicated
//   write data. Handles a variable-latency memory via a req/ready handshake with
//   a pipeline stall and extends load data. Registers the outcome into the
//   MEM/WB register, including the hazard-unit Tnew countdown.
// PARAMETERS
//   TIMEOUT   16   max wait cycles for dm_ready before bus_err_w (1..255)
// PORTS
//   clk          in   1   single clock; all state updates on posedge
//   rst_n        in   1   asynchronous, active-low reset
//   regWriteM    in   1   instruction writes the register file
//   memToRegM    in   1   instruction is a load
//   memWriteM    in   2   0 none, 1 sw, 2 sh, 3 sb
//   jalOpM       in   1   link instruction (WB selects pc+8)
//   aluOutM      in   32  effective address / ALU result
//   writeDataM   in   32  store data (already forwarded)
//   writeRegM    in   5   destination register
//   pcM          in   32  instruction PC
//   TnewM        in   2   cycles until result ready
//   lOpM         in   3   0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu (5..7 treated as lw)
//   dm_req       out  1   memory request, level, held until dm_ready
//   dm_we        out  1   1 = store
//   dm_be        out  4   byte enables, little-endian
//   dm_addr      out  32  word-aligned address {aluOutM[31:2],2'b00}
//   dm_wdata     out  32  store data replicated to lanes
//   dm_ready     in   1   memory completes access this cycle
//   dm_rdata     in   32  load word, valid when dm_ready
//   stall_m      out  1   freeze PC/IF/ID/EX/MEM registers
//   regWriteW, memToRegW, jalOpW  out 1 each;  aluOutW, readDataW, pcW  out 32
//   writeRegW out 5;  TnewW out 2;  bus_err_w out 1;  adel_w, ades_w out 1 each
// BEHAVIOUR
//   - Reset: all W outputs 0, FSM IDLE, wait counter 0; dm_req deasserts
//     immediately and asynchronously.
//   - mem_op = memToRegM | (memWriteM!=0). dm_req = mem_op & ~bus_err_hold &
//     ~misaligned (misaligned is 0 unless ADDR_EXC_EN is defined).
//   - dm_be: sw 1111; sh addr[1]?1100:0011; sb 0001<<addr[1:0]; load 1111.
//   - dm_wdata: sw data; sh {2{d[15:0]}}; sb {4{d[7:0]}}.
//   - stall_m = dm_req & ~dm_ready (combinational). A 0-wait memory
//     (ready same cycle) causes no stall.
//   - FSM IDLE->WAIT when dm_req & ~dm_ready. WAIT->IDLE on dm_ready. Wait
//     counter increments each WAIT cycle.
//   - Timeout: counter==TIMEOUT-1 without ready returns to IDLE, raises
//     bus_err_w for one W cycle, and drops stall. A request already in flight is
//     abandoned; bus_err_hold blocks a re-request for that same M instruction.
//   - W register capture each cycle:
//     - stall_m=1: bubble (regWriteW=0, memToRegW=0, jalOpW=0, TnewW=0).
//     - stall_m=0: fields copied from M.
//     - TnewW = (TnewM==0) ? 0 : TnewM-1.
//     - readDataW = dm_rdata lane selected by addr[1:0]; lh/lb sign-extend,
//       lhu/lbu zero-extend. On timeout readDataW=0 and regWriteW=0.
//   - dm_ready arriving while dm_req=0 is ignored.
//   - Reset asserted mid-WAIT aborts the access. No retry after reset.
// CONFIGURATION
//   ADDR_EXC_EN defined: misaligned when lw/sw addr[1:0]!=0 or lh/lhu/sh
//     addr[0]!=0. Then dm_req=0 and no stall. The W capture sets adel_w (load)
//     or ades_w (store) with regWriteW=0.
//   ADDR_EXC_EN undefined: adel_w=ades_w=0 constant. Low address bits are
//     ignored for word ops, and addr[0] is ignored for halfword ops.
// TESTING
//   - sw 0x12345678 @0x100, dm_ready same cycle -> dm_be=1111, dm_we=1,
//     stall_m never high, regWriteW=0.
//   - lb @0x103, rdata 0x80FF_FF7F, ready after 3 cycles -> stall_m high 3
//     cycles, 3 bubbles, readDataW=0xFFFF_FF80.
//   - sh 0x0000ABCD @0x102 -> dm_be=1100, dm_wdata=0xABCD_ABCD.
//   - addu with TnewM=2 -> no dm_req, TnewW=1, aluOutW passes through next edge.
//   - lw, dm_ready held low, TIMEOUT=4 -> stall 4 cycles, bus_err_w=1 one cycle,
//     regWriteW=0, no re-request.
//   - ADDR_EXC_EN: lw @0x101 -> dm_req=0, adel_w=1; rst_n low mid-WAIT -> dm_req
//     and all W outputs 0 immediately.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory port drive, store lane steering, load extension, MEM/WB register.
// Latency: 1 cycle to W; variable memory wait holds stall_m until dm_ready or TIMEOUT.
// Optional ADDR_EXC_EN macro enables misaligned-address exceptions (adel_w/ades_w).
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic [1:0]  memWriteM,
    input  logic        jalOpM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    input  logic [4:0]  writeRegM,
    input  logic [31:0] pcM,
    input  logic [1:0]  TnewM,
    input  logic [2:0]  lOpM,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        stall_m,
    output logic        regWriteW,
    output logic        memToRegW,
    output logic        jalOpW,
    output logic [31:0] aluOutW,
    output logic [31:0] readDataW,
    output logic [31:0] pcW,
    output logic [4:0]  writeRegW,
    output logic [1:0]  TnewW,
    output logic        bus_err_w,
    output logic        adel_w,
    output logic        ades_w
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        bus_err_hold;
    logic        mem_op;
    logic        mis_ld;
    logic        mis_st;
    logic        misaligned;
    logic        timeout;
    logic [1:0]  tnew_dec;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign mem_op = memToRegM | (memWriteM != 2'd0);

`ifdef ADDR_EXC_EN
    logic word_ld;
    logic half_ld;
    assign word_ld = (lOpM == 3'd0) || (lOpM > 3'd4);
    assign half_ld = (lOpM == 3'd1) || (lOpM == 3'd2);
    assign mis_ld  = memToRegM & ((word_ld & (aluOutM[1:0] != 2'b00)) | (half_ld & aluOutM[0]));
    assign mis_st  = ((memWriteM == 2'd1) & (aluOutM[1:0] != 2'b00)) |
                     ((memWriteM == 2'd2) & aluOutM[0]);
`else
    assign mis_ld  = 1'b0;
    assign mis_st  = 1'b0;
`endif
    assign misaligned = mis_ld | mis_st;

    // Gating with rst_n drops the request the moment reset is asserted.
    assign dm_req   = rst_n & mem_op & ~bus_err_hold & ~misaligned;
    assign dm_we    = (memWriteM != 2'd0);
    assign dm_addr  = {aluOutM[31:2], 2'b00};
    assign stall_m  = dm_req & ~dm_ready;
    assign timeout  = stall_m & (wait_cnt == 8'(TIMEOUT - 1));
    assign tnew_dec = (TnewM == 2'd0) ? 2'd0 : TnewM - 2'd1;

    always_comb begin
        dm_be    = 4'b1111;
        dm_wdata = writeDataM;
        case (memWriteM)
            2'd2: begin
                dm_be    = aluOutM[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{writeDataM[15:0]}};
            end
            2'd3: begin
                dm_be    = 4'b0001 << aluOutM[1:0];
                dm_wdata = {4{writeDataM[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dm_rdata[7:0];
        case (aluOutM[1:0])
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            2'd3:    ld_byte = dm_rdata[31:24];
            default: ;
        endcase
        ld_half = aluOutM[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (lOpM)
            3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd2:    ld_ext = {16'h0000, ld_half};
            3'd3:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_ext = {24'h000000, ld_byte};
            default: ld_ext = dm_rdata;
        endcase
    end

    // wait_cnt counts stalled cycles of the current access, including the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            bus_err_hold <= 1'b0;
        end else if (timeout) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            bus_err_hold <= 1'b1;
        end else begin
            bus_err_hold <= 1'b0;
            case (state)
                IDLE: if (stall_m) begin
                    state    <= WAIT;
                    wait_cnt <= wait_cnt + 8'd1;
                end
                WAIT: if (!stall_m) begin
                    state    <= IDLE;
                    wait_cnt <= 8'd0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            jalOpW    <= 1'b0;
            aluOutW   <= 32'd0;
            readDataW <= 32'd0;
            pcW       <= 32'd0;
            writeRegW <= 5'd0;
            TnewW     <= 2'd0;
            bus_err_w <= 1'b0;
            adel_w    <= 1'b0;
            ades_w    <= 1'b0;
        end else begin
            aluOutW   <= aluOutM;
            pcW       <= pcM;
            writeRegW <= writeRegM;
            readDataW <= bus_err_hold ? 32'd0 : ld_ext;
            bus_err_w <= bus_err_hold;
            if (stall_m) begin
                regWriteW <= 1'b0;
                memToRegW <= 1'b0;
                jalOpW    <= 1'b0;
                TnewW     <= 2'd0;
                adel_w    <= 1'b0;
                ades_w    <= 1'b0;
            end else begin
                regWriteW <= regWriteM & ~misaligned & ~bus_err_hold;
                memToRegW <= memToRegM;
                jalOpW    <= jalOpM;
                TnewW     <= tnew_dec;
                adel_w    <= mis_ld;
                ades_w    <= mis_st;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized plus directed bench for mem_access_stage against a transaction-level model.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        regWriteM, memToRegM, jalOpM;
    logic [1:0]  memWriteM, TnewM;
    logic [31:0] aluOutM, writeDataM, pcM;
    logic [4:0]  writeRegM;
    logic [2:0]  lOpM;
    logic        dm_req, dm_we, dm_ready, stall_m;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        regWriteW, memToRegW, jalOpW, bus_err_w, adel_w, ades_w;
    logic [31:0] aluOutW, readDataW, pcW;
    logic [4:0]  writeRegW;
    logic [1:0]  TnewW;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
        .jalOpM(jalOpM), .aluOutM(aluOutM), .writeDataM(writeDataM),
        .writeRegM(writeRegM), .pcM(pcM), .TnewM(TnewM), .lOpM(lOpM),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .stall_m(stall_m), .regWriteW(regWriteW), .memToRegW(memToRegW),
        .jalOpW(jalOpW), .aluOutW(aluOutW), .readDataW(readDataW), .pcW(pcW),
        .writeRegW(writeRegW), .TnewW(TnewW), .bus_err_w(bus_err_w),
        .adel_w(adel_w), .ades_w(ades_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rw, m2r, jal;
        bit [1:0]  mw, tn;
        bit [31:0] alu, wd, pc;
        bit [4:0]  wr;
        bit [2:0]  lop;
    } op_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input op_t o);
        regWriteM  = o.rw;  memToRegM = o.m2r; memWriteM = o.mw; jalOpM = o.jal;
        aluOutM    = o.alu; writeDataM = o.wd; writeRegM = o.wr; pcM = o.pc;
        TnewM      = o.tn;  lOpM = o.lop;
    endtask

    function automatic bit is_mis_ld(op_t o);
`ifdef ADDR_EXC_EN
        if (!o.m2r) return 0;
        if (o.lop == 1 || o.lop == 2) return o.alu % 2 != 0;
        if (o.lop == 3 || o.lop == 4) return 0;
        return o.alu % 4 != 0;
`else
        return 0;
`endif
    endfunction

    function automatic bit is_mis_st(op_t o);
`ifdef ADDR_EXC_EN
        if (o.mw == 1) return o.alu % 4 != 0;
        if (o.mw == 2) return o.alu % 2 != 0;
        return 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [3:0] be_model(op_t o);
        int lane = o.alu % 4;
        if (o.mw == 2) return (lane >= 2) ? 4'b1100 : 4'b0011;
        if (o.mw == 3) return 4'(1 << lane);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_model(op_t o);
        logic [31:0] h = o.wd & 32'hFFFF;
        logic [31:0] b = o.wd & 32'hFF;
        if (o.mw == 2) return h * 32'h0001_0001;
        if (o.mw == 3) return b * 32'h0101_0101;
        return o.wd;
    endfunction

    function automatic logic [31:0] ld_model(op_t o, logic [31:0] rd);
        int lane = o.alu % 4;
        logic [31:0] b = (rd >> (8 * lane)) & 32'hFF;
        logic [31:0] h = (rd >> (16 * (lane / 2))) & 32'hFFFF;
        case (o.lop)
            1: return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            2: return h;
            3: return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            4: return b;
            default: return rd;
        endcase
    endfunction

    task automatic chk_port(input op_t o);
        chk("dm_addr", dm_addr, o.alu & 32'hFFFF_FFFC);
        chk("dm_be", {28'd0, dm_be}, {28'd0, be_model(o)});
        chk("dm_we", {31'd0, dm_we}, {31'd0, o.mw != 0});
        if (o.mw != 0) chk("dm_wdata", dm_wdata, wdata_model(o));
    endtask

    // Entered and left at posedge+1; lat = cycles before dm_ready rises.
    task automatic do_op(input op_t o, input int lat, input logic [31:0] rd);
        bit memop = o.m2r || (o.mw != 0);
        bit mld   = is_mis_ld(o);
        bit mst   = is_mis_st(o);
        bit req   = memop && !(mld || mst);
        bit to    = req && (lat >= TO);
        int ns    = !req ? 0 : (to ? TO : lat);
        drive(o);
        for (int c = 0; c < ns; c++) begin
            dm_ready = 1'b0;
            dm_rdata = $urandom;
            @(negedge clk);
            chk("req_wait", {31'd0, dm_req}, 32'd1);
            chk("stall_wait", {31'd0, stall_m}, 32'd1);
            if (c == 0) chk_port(o);
            @(posedge clk); #1;
            chk("bubble_rw", {31'd0, regWriteW}, 32'd0);
            chk("bubble_m2r", {31'd0, memToRegW}, 32'd0);
            chk("bubble_jal", {31'd0, jalOpW}, 32'd0);
            chk("bubble_tnew", {30'd0, TnewW}, 32'd0);
            chk("bubble_err", {31'd0, bus_err_w}, 32'd0);
        end
        if (to) begin
            dm_ready = 1'b0;
            @(negedge clk);
            chk("no_rereq", {31'd0, dm_req}, 32'd0);
            chk("to_stall", {31'd0, stall_m}, 32'd0);
            @(posedge clk); #1;
            chk("to_err", {31'd0, bus_err_w}, 32'd1);
            chk("to_rw", {31'd0, regWriteW}, 32'd0);
            chk("to_rdata", readDataW, 32'd0);
        end else begin
            dm_ready = req ? 1'b1 : 1'($urandom % 2);
            dm_rdata = rd;
            @(negedge clk);
            chk("req_done", {31'd0, dm_req}, {31'd0, req});
            chk("stall_done", {31'd0, stall_m}, 32'd0);
            if (req && ns == 0) chk_port(o);
            @(posedge clk); #1;
            chk("w_rw", {31'd0, regWriteW}, {31'd0, o.rw && !(mld || mst)});
            chk("w_m2r", {31'd0, memToRegW}, {31'd0, o.m2r});
            chk("w_jal", {31'd0, jalOpW}, {31'd0, o.jal});
            chk("w_alu", aluOutW, o.alu);
            chk("w_pc", pcW, o.pc);
            chk("w_wr", {27'd0, writeRegW}, {27'd0, o.wr});
            chk("w_tnew", {30'd0, TnewW}, (o.tn == 0) ? 32'd0 : 32'(o.tn) - 1);
            chk("w_err", {31'd0, bus_err_w}, 32'd0);
            chk("w_adel", {31'd0, adel_w}, {31'd0, mld});
            chk("w_ades", {31'd0, ades_w}, {31'd0, mst});
            if (req && o.m2r) chk("w_rdata", readDataW, ld_model(o, rd));
        end
        dm_ready = 1'b0;
    endtask

    function automatic op_t rand_op();
        op_t o;
        int kind = $urandom_range(0, 2);
        o.alu = $urandom; o.wd = $urandom; o.pc = $urandom & 32'hFFFF_FFFC;
        o.wr  = 5'($urandom); o.tn = 2'($urandom); o.lop = 3'($urandom);
        o.jal = 0; o.m2r = 0; o.mw = 0; o.rw = 0;
        case (kind)
            0: begin o.rw = 1; o.jal = 1'($urandom); end
            1: begin o.rw = 1; o.m2r = 1; end
            default: o.mw = 2'($urandom_range(1, 3));
        endcase
        return o;
    endfunction

    function automatic op_t mk(bit rw, bit m2r, bit [1:0] mw, bit [2:0] lop,
                               bit [31:0] alu, bit [31:0] wd, bit [1:0] tn);
        op_t o;
        o.rw = rw; o.m2r = m2r; o.mw = mw; o.lop = lop; o.alu = alu; o.wd = wd;
        o.tn = tn; o.jal = 0; o.pc = 32'h0040_0000 + alu; o.wr = 5'd9;
        return o;
    endfunction

    initial begin
        op_t o;
        dm_ready = 1'b0;
        dm_rdata = 32'd0;
        drive(mk(0, 0, 2'd1, 3'd0, 32'h100, 32'h1234_5678, 2'd0));
        #2;
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        chk("rst_rw", {31'd0, regWriteW}, 32'd0);
        chk("rst_alu", aluOutW, 32'd0);
        chk("rst_rdata", readDataW, 32'd0);
        chk("rst_tnew", {30'd0, TnewW}, 32'd0);
        chk("rst_err", {31'd0, bus_err_w}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(mk(0, 0, 2'd1, 3'd0, 32'h100, 32'h1234_5678, 2'd0), 0, 32'd0);
        do_op(mk(1, 1, 2'd0, 3'd3, 32'h103, 32'h0, 2'd2), 3, 32'h80FF_FF7F);
        do_op(mk(0, 0, 2'd2, 3'd0, 32'h102, 32'h0000_ABCD, 2'd0), 1, 32'd0);
        do_op(mk(1, 0, 2'd0, 3'd0, 32'hCAFE_0004, 32'h0, 2'd2), 0, 32'd0);
        do_op(mk(1, 1, 2'd0, 3'd0, 32'h200, 32'h0, 2'd1), 100, 32'd0);
        do_op(mk(1, 1, 2'd0, 3'd2, 32'h206, 32'h0, 2'd3), 2, 32'hBEEF_1234);
        do_op(mk(1, 1, 2'd0, 3'd1, 32'h20A, 32'h0, 2'd3), TO - 1, 32'h9ABC_0000);
        do_op(mk(0, 0, 2'd3, 3'd0, 32'h301, 32'h0000_00A5, 2'd0), 0, 32'd0);
        do_op(mk(1, 1, 2'd0, 3'd0, 32'h101, 32'h0, 2'd2), 0, 32'h1111_2222);

        for (int i = 0; i < 60; i++)
            do_op(rand_op(), $urandom_range(0, TO + 2), $urandom);

        // reset in the middle of a pending load
        o = mk(1, 1, 2'd0, 3'd0, 32'h400, 32'h0, 2'd2);
        drive(o);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_stall", {31'd0, stall_m}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, dm_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_m}, 32'd0);
        chk("mid_rst_alu", aluOutW, 32'd0);
        chk("mid_rst_pc", pcW, 32'd0);
        chk("mid_rst_wr", {27'd0, writeRegW}, 32'd0);
        drive(mk(0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 2'd0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'd0, dm_req}, 32'd0);
        @(posedge clk); #1;
        do_op(mk(1, 1, 2'd0, 3'd4, 32'h502, 32'h0, 2'd1), 1, 32'h00C3_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
